mandel_scheduler: RTL and testbench

- Schedules pixel jobs onto NUM_ENGINES parallel divergence engines. Each engine is the ld/a/b/diverged datapath that iterates z <- z^2 + c and flags when |z|^2 exceeds its threshold.
- Accepts pixel jobs (c = a + ib plus a pixel tag) on a valid/ready input and dispatches each job to a free engine.
- Counts iterations per engine until divergence or the max-iteration limit.
- Returns results on a registered valid/ready output, arbitrated round-robin across finished engines.

---
 rtl/mandel_pkg.sv | 22 ++
 rtl/mandel_if.sv | 31 +++
 rtl/mandel_engine_ctl.sv | 113 +++++++++++
 rtl/mandel_scheduler.sv | 140 ++++++++++++++
 tb/tb_mandel_scheduler.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mandel_pkg.sv
// Shared types and defaults for the Mandelbrot engine scheduler.
//   eng_state_e     : per-engine lifecycle (IDLE -> RUN -> DONE -> IDLE)
//   mandel_result_t : finished-job record at the default tag/iteration widths
package mandel_pkg;

    localparam int unsigned DEF_ITER_W = 16;
    localparam int unsigned DEF_TAG_W  = 20;
    localparam int unsigned C_W        = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } eng_state_e;

    typedef struct packed {
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_ITER_W-1:0] iter;
        logic                  escaped;
    } mandel_result_t;

endpackage

// File: rtl/mandel_if.sv
// Job and result channels of the scheduler.
//   in_*  : job request (valid/ready), c = in_a + i*in_b, pixel tag
//   out_* : finished-job result (valid/ready)
// master = job producer / result consumer, slave = scheduler.
interface mandel_if
    import mandel_pkg::*;
#(
    parameter int unsigned ITER_W = DEF_ITER_W,
    parameter int unsigned TAG_W  = DEF_TAG_W
);
    logic              in_valid;
    logic              in_ready;
    logic [C_W-1:0]    in_a;
    logic [C_W-1:0]    in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_tag;
    logic [ITER_W-1:0] out_iter;
    logic              out_escaped;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_tag, out_iter, out_escaped
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_tag, out_iter, out_escaped
    );
endinterface

// File: rtl/mandel_engine_ctl.sv
// Controller for one divergence engine: holds c, tag and limit of the
// current job and counts engine updates until divergence or the limit.
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_start               : job dispatched to this engine (only honoured in IDLE)
//   i_a, i_b, i_tag       : job payload latched on i_start
//   i_limit               : iteration limit (already forced >= 1)
//   i_diverged            : engine divergence flag
//   i_release             : result taken by the output register (DONE -> IDLE)
//   o_state               : current lifecycle state
//   o_ld                  : engine hold-at-zero, low only while RUN
//   o_a, o_b              : latched c
//   o_tag, o_iter, o_escaped : result of the finished job
module mandel_engine_ctl
    import mandel_pkg::*;
#(
    parameter int unsigned ITER_W = DEF_ITER_W,
    parameter int unsigned TAG_W  = DEF_TAG_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [C_W-1:0]    i_a,
    input  logic [C_W-1:0]    i_b,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic [ITER_W-1:0] i_limit,
    input  logic              i_diverged,
    input  logic              i_release,
    output eng_state_e        o_state,
    output logic              o_ld,
    output logic [C_W-1:0]    o_a,
    output logic [C_W-1:0]    o_b,
    output logic [TAG_W-1:0]  o_tag,
    output logic [ITER_W-1:0] o_iter,
    output logic              o_escaped
);

    eng_state_e        r_state;
    eng_state_e        w_next;
    logic              r_ld;
    logic [C_W-1:0]    r_a;
    logic [C_W-1:0]    r_b;
    logic [TAG_W-1:0]  r_tag;
    logic [ITER_W-1:0] r_limit;
    logic [ITER_W-1:0] r_k;
    logic              r_esc;

    // Next-state logic; divergence and limit both end the run
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_next = ST_RUN;
            ST_RUN:  if (i_diverged || (r_k == r_limit)) w_next = ST_DONE;
            ST_DONE: if (i_release) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register; ld is registered from the next state so it is glitch-free
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ld    <= 1'b1;
        end else begin
            r_state <= w_next;
            r_ld    <= (w_next != ST_RUN);
        end
    end

    // Job registers and iteration counter; k is frozen in DONE and is the result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_tag   <= '0;
            r_limit <= '0;
            r_k     <= '0;
            r_esc   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_tag   <= i_tag;
                        r_limit <= i_limit;
                        r_k     <= '0;
                        r_esc   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (i_diverged) begin
                        r_esc <= 1'b1;
                    end else if (r_k == r_limit) begin
                        r_esc <= 1'b0;
                    end else begin
                        r_k <= r_k + ITER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_state   = r_state;
    assign o_ld      = r_ld;
    assign o_a       = r_a;
    assign o_b       = r_b;
    assign o_tag     = r_tag;
    assign o_iter    = r_k;
    assign o_escaped = r_esc;

endmodule

// File: rtl/mandel_scheduler.sv
// Dispatches pixel jobs to NUM_ENGINES divergence engines and returns
// results through a single registered output slot, round-robin across
// finished engines.
// Ports:
//   aclk, areset   : clock, synchronous active-high reset
//   cfg_max_iter   : iteration limit sampled per job (0 behaves as 1)
//   io             : job input / result output channels (slave side)
//   eng_ld         : per-engine hold-at-zero
//   eng_a, eng_b   : per-engine c, engine e at [32e+31:32e]
//   eng_diverged   : per-engine divergence flag
//   busy           : any engine active or a result pending
module mandel_scheduler
    import mandel_pkg::*;
#(
    parameter int unsigned NUM_ENGINES = 4,
    parameter int unsigned ITER_W      = DEF_ITER_W,
    parameter int unsigned TAG_W       = DEF_TAG_W
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [ITER_W-1:0]          cfg_max_iter,
    mandel_if.slave                    io,
    output logic [NUM_ENGINES-1:0]     eng_ld,
    output logic [C_W*NUM_ENGINES-1:0] eng_a,
    output logic [C_W*NUM_ENGINES-1:0] eng_b,
    input  logic [NUM_ENGINES-1:0]     eng_diverged,
    output logic                       busy
);

    localparam int unsigned IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [ITER_W-1:0] iter;
        logic              escaped;
    } res_t;

    eng_state_e             w_state [NUM_ENGINES];
    logic [TAG_W-1:0]       w_tag   [NUM_ENGINES];
    logic [ITER_W-1:0]      w_iter  [NUM_ENGINES];
    logic [NUM_ENGINES-1:0] w_esc;
    logic [NUM_ENGINES-1:0] w_idle;
    logic [NUM_ENGINES-1:0] w_done;
    logic [NUM_ENGINES-1:0] w_start;
    logic [NUM_ENGINES-1:0] w_release;
    logic [IDX_W-1:0]       w_free_idx;
    logic [IDX_W-1:0]       w_win;
    logic                   w_accept;
    logic                   w_load;
    logic [ITER_W-1:0]      w_limit;

    logic                   r_out_valid;
    res_t                   r_out;
    logic [IDX_W-1:0]       r_rr_ptr;

    always_comb begin
        for (int e = 0; e < int'(NUM_ENGINES); e++) begin
            w_idle[e] = (w_state[e] == ST_IDLE);
            w_done[e] = (w_state[e] == ST_DONE);
        end
    end

    assign w_limit  = (cfg_max_iter == '0) ? ITER_W'(1) : cfg_max_iter;
    assign w_accept = io.in_valid && (|w_idle);

    // Lowest-index idle engine takes the accepted job
    always_comb begin
        w_free_idx = '0;
        for (int e = int'(NUM_ENGINES) - 1; e >= 0; e--) begin
            if (w_idle[e]) w_free_idx = IDX_W'(e);
        end
        w_start             = '0;
        w_start[w_free_idx] = w_accept;
    end

    // Round-robin pick: lowest DONE at/after rr_ptr, else lowest DONE overall
    always_comb begin
        w_win = '0;
        for (int e = int'(NUM_ENGINES) - 1; e >= 0; e--) begin
            if (w_done[e]) w_win = IDX_W'(e);
        end
        for (int e = int'(NUM_ENGINES) - 1; e >= 0; e--) begin
            if (w_done[e] && (e >= int'(r_rr_ptr))) w_win = IDX_W'(e);
        end
    end

    assign w_load = (|w_done) && (!r_out_valid || io.out_ready);

    always_comb begin
        w_release        = '0;
        w_release[w_win] = w_load;
    end

    // Single-slot output register; reloads in the same cycle it is consumed
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out       <= '{tag: w_tag[w_win], iter: w_iter[w_win], escaped: w_esc[w_win]};
            r_rr_ptr    <= (w_win == IDX_W'(NUM_ENGINES - 1)) ? '0 : w_win + IDX_W'(1);
        end else if (io.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    for (genvar e = 0; e < NUM_ENGINES; e++) begin : g_eng
        mandel_engine_ctl #(
            .ITER_W (ITER_W),
            .TAG_W  (TAG_W)
        ) u_ctl (
            .i_clk      (aclk),
            .i_rst      (areset),
            .i_start    (w_start[e]),
            .i_a        (io.in_a),
            .i_b        (io.in_b),
            .i_tag      (io.in_tag),
            .i_limit    (w_limit),
            .i_diverged (eng_diverged[e]),
            .i_release  (w_release[e]),
            .o_state    (w_state[e]),
            .o_ld       (eng_ld[e]),
            .o_a        (eng_a[C_W*e +: C_W]),
            .o_b        (eng_b[C_W*e +: C_W]),
            .o_tag      (w_tag[e]),
            .o_iter     (w_iter[e]),
            .o_escaped  (w_esc[e])
        );
    end

    assign io.in_ready    = |w_idle;
    assign io.out_valid   = r_out_valid;
    assign io.out_tag     = r_out.tag;
    assign io.out_iter    = r_out.iter;
    assign io.out_escaped = r_out.escaped;
    assign busy           = r_out_valid || !(&w_idle);

endmodule

// File: tb/tb_mandel_scheduler.sv
// Directed bench for mandel_scheduler with four engine models: a Q4.28
// fixed-point z <- z^2 + c engine (|z|^2 > 4 diverges) and a scripted stub
// whose divergence flag rises after a chosen number of updates.
module tb_mandel_scheduler;

    localparam int NE = 4;
    localparam int IW = 16;
    localparam int TW = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic [IW-1:0]    cfg_max_iter;
    logic [NE-1:0]    eng_ld;
    logic [NE-1:0]    eng_div;
    logic [32*NE-1:0] eng_a;
    logic [32*NE-1:0] eng_b;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mandel_if #(.ITER_W(IW), .TAG_W(TW)) io ();

    mandel_scheduler #(
        .NUM_ENGINES (NE),
        .ITER_W      (IW),
        .TAG_W       (TW)
    ) dut (
        .aclk         (clk),
        .areset       (rst),
        .cfg_max_iter (cfg_max_iter),
        .io           (io),
        .eng_ld       (eng_ld),
        .eng_a        (eng_a),
        .eng_b        (eng_b),
        .eng_diverged (eng_div),
        .busy         (busy)
    );

    // Engine models
    bit                 stub_mode;
    int                 div_at [NE];
    int                 upd    [NE];
    logic signed [31:0] zr     [NE];
    logic signed [31:0] zi     [NE];

    function automatic logic signed [31:0] qmul(input logic signed [31:0] x, input logic signed [31:0] y);
        longint p;
        p = longint'(x) * longint'(y);
        return 32'(p >>> 28);
    endfunction

    function automatic logic real_div(input logic signed [31:0] r, input logic signed [31:0] i);
        longint m;
        m = longint'(r) * longint'(r) + longint'(i) * longint'(i);
        return m > (longint'(4) <<< 56);
    endfunction

    always @(posedge clk) begin
        for (int e = 0; e < NE; e++) begin
            if (eng_ld[e]) begin
                zr[e]  <= '0;
                zi[e]  <= '0;
                upd[e] <= 0;
            end else begin
                zr[e]  <= qmul(zr[e], zr[e]) - qmul(zi[e], zi[e]) + $signed(eng_a[32*e +: 32]);
                zi[e]  <= (qmul(zr[e], zi[e]) <<< 1) + $signed(eng_b[32*e +: 32]);
                upd[e] <= upd[e] + 1;
            end
        end
    end

    always_comb begin
        eng_div = '0;
        for (int e = 0; e < NE; e++) begin
            eng_div[e] = stub_mode ? (!eng_ld[e] && (upd[e] >= div_at[e])) : real_div(zr[e], zi[e]);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns the cycle in which the job was accepted
    task automatic accept_job(input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] tag, output int t_acc);
        int w;
        w = 0;
        io.in_valid = 1'b1;
        io.in_a     = a;
        io.in_b     = b;
        io.in_tag   = tag;
        while (!io.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!io.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: tag 0x%0h not accepted within 200 cycles", tag);
        end
        t_acc = cyc;
        @(negedge clk);
        io.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int limit, output int t_out);
        int w;
        w = 0;
        while (!io.out_valid && w < limit) begin
            @(negedge clk);
            w++;
        end
        chk("out_valid_timeout", 64'(io.out_valid), 64'd1);
        t_out = cyc;
    endtask

    typedef struct {
        bit          use_real;
        logic [31:0] a;
        logic [31:0] b;
        logic [19:0] tag;
        logic [15:0] max_iter;
        int          div_at;
        logic [15:0] exp_iter;
        logic        exp_esc;
        int          exp_lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, t5;
        bit seen;
        logic [TW-1:0] hold_tag;
        logic [TW-1:0] exp_tags [4];
        logic [IW-1:0] exp_iters [4];

        //                 real  a             b             tag       max     div iter    esc  lat
        vecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 20'h00A01, 16'd50, 0, 16'd50, 1'b0, 53};
        vecs[1] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 20'h00005, 16'd50, 1, 16'd1,  1'b1, 4};
        vecs[2] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 20'h00A02, 16'd0,  0, 16'd1,  1'b0, 4};
        vecs[3] = '{1'b1, 32'h1000_0000, 32'h0000_0000, 20'h00A03, 16'd50, 0, 16'd3,  1'b1, 6};
        vecs[4] = '{1'b1, 32'hE000_0000, 32'h0000_0000, 20'h00A04, 16'd10, 0, 16'd10, 1'b0, 13};
        vecs[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 20'h00A05, 16'd5,  5, 16'd5,  1'b1, 8};
        vecs[6] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 20'h00A06, 16'd3,  7, 16'd3,  1'b0, 6};
        vecs[7] = '{1'b1, 32'h0000_0000, 32'h2000_0000, 20'h00A07, 16'd50, 0, 16'd2,  1'b1, 5};

        rst          = 1'b1;
        stub_mode    = 1'b1;
        cfg_max_iter = 16'd50;
        io.in_valid  = 1'b0;
        io.in_a      = '0;
        io.in_b      = '0;
        io.in_tag    = '0;
        io.out_ready = 1'b1;
        for (int e = 0; e < NE; e++) div_at[e] = 1000;
        @(negedge clk);
        apply_reset();

        // Reset state
        chk("rst_out_valid",   64'(io.out_valid),   64'd0);
        chk("rst_eng_ld",      64'(eng_ld),         64'hF);
        chk("rst_in_ready",    64'(io.in_ready),    64'd1);
        chk("rst_busy",        64'(busy),           64'd0);
        chk("rst_out_tag",     64'(io.out_tag),     64'd0);
        chk("rst_out_iter",    64'(io.out_iter),    64'd0);
        chk("rst_out_escaped", 64'(io.out_escaped), 64'd0);

        // Single-job vectors on engine 0
        for (int i = 0; i < 8; i++) begin
            stub_mode    = !vecs[i].use_real;
            div_at[0]    = vecs[i].div_at;
            cfg_max_iter = vecs[i].max_iter;
            accept_job(vecs[i].a, vecs[i].b, vecs[i].tag, t0);
            wait_out(200, t1);
            chk($sformatf("v%0d_iter", i),    64'(io.out_iter),    64'(vecs[i].exp_iter));
            chk($sformatf("v%0d_escaped", i), 64'(io.out_escaped), 64'(vecs[i].exp_esc));
            chk($sformatf("v%0d_tag", i),     64'(io.out_tag),     64'(vecs[i].tag));
            chk($sformatf("v%0d_latency", i), 64'(t1 - t0),        64'(vecs[i].exp_lat));
            @(negedge clk);
            chk($sformatf("v%0d_drained", i), 64'(io.out_valid),   64'd0);
        end

        // Minimum-latency job: ld low only in T+1..T+2, out_valid exactly at T+4
        stub_mode    = 1'b1;
        div_at[0]    = 1;
        cfg_max_iter = 16'd50;
        apply_reset();
        accept_job(32'h0, 32'h0, 20'h00005, t0);
        for (int d = 1; d <= 4; d++) begin
            chk($sformatf("min_ld_T+%0d", d),    64'(eng_ld[0]),    64'(d >= 3));
            chk($sformatf("min_valid_T+%0d", d), 64'(io.out_valid), 64'(d == 4));
            if (d < 4) @(negedge clk);
        end
        chk("min_iter",    64'(io.out_iter),    64'd1);
        chk("min_escaped", 64'(io.out_escaped), 64'd1);
        @(negedge clk);

        // Fill all engines, offer a fifth job that must wait for engine 0 to free
        apply_reset();
        for (int e = 0; e < NE; e++) div_at[e] = 20;
        accept_job(32'h100, 32'h200, 20'd1, t0);
        accept_job(32'h101, 32'h201, 20'd2, t1);
        accept_job(32'h102, 32'h202, 20'd3, t1);
        accept_job(32'h103, 32'h203, 20'd4, t1);
        chk("fill_in_ready_low", 64'(io.in_ready), 64'd0);
        chk("fill_eng_ld",       64'(eng_ld),      64'h0);
        for (int e = 0; e < NE; e++) begin
            chk($sformatf("fill_eng_a%0d", e), 64'(eng_a[32*e +: 32]), 64'(32'h100 + e));
            chk($sformatf("fill_eng_b%0d", e), 64'(eng_b[32*e +: 32]), 64'(32'h200 + e));
        end
        accept_job(32'h555, 32'h666, 20'd5, t5);
        chk("fill_fifth_accept_cycle", 64'(t5 - t0),         64'd23);
        chk("fill_fifth_on_eng0",      64'(eng_a[31:0]),     64'h555);

        // Simultaneous completion with rr_ptr = 1, output held then drained
        apply_reset();
        div_at[0] = 1;
        accept_job(32'h0, 32'h0, 20'h10, t0);
        wait_out(20, t1);
        chk("rr_pre_tag", 64'(io.out_tag), 64'h10);
        @(negedge clk);
        io.out_ready = 1'b0;
        for (int e = 0; e < NE; e++) div_at[e] = 6 - e;
        for (int e = 0; e < NE; e++) accept_job(32'h0, 32'h0, TW'(32'h11 + e), t1);
        wait_out(30, t1);
        hold_tag = 20'h12;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold_valid_%0d", i), 64'(io.out_valid), 64'd1);
            chk($sformatf("hold_tag_%0d", i),   64'(io.out_tag),   64'(hold_tag));
            @(negedge clk);
        end
        exp_tags  = '{20'h12, 20'h13, 20'h14, 20'h11};
        exp_iters = '{16'd5, 16'd4, 16'd3, 16'd6};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_valid_%0d", i), 64'(io.out_valid), 64'd1);
            chk($sformatf("drain_tag_%0d", i),   64'(io.out_tag),   64'(exp_tags[i]));
            chk($sformatf("drain_iter_%0d", i),  64'(io.out_iter),  64'(exp_iters[i]));
            io.out_ready = 1'b1;
            @(negedge clk);
        end
        chk("drain_empty", 64'(io.out_valid), 64'd0);
        chk("drain_busy",  64'(busy),         64'd0);

        // Reset with three engines running and a result held
        apply_reset();
        io.out_ready = 1'b0;
        div_at[0] = 1;
        accept_job(32'h0, 32'h0, 20'h20, t0);
        wait_out(20, t1);
        for (int e = 0; e < NE; e++) div_at[e] = 50;
        accept_job(32'h0, 32'h0, 20'h21, t1);
        accept_job(32'h0, 32'h0, 20'h22, t1);
        accept_job(32'h0, 32'h0, 20'h23, t1);
        chk("mid_pre_eng_ld",    64'(eng_ld),       64'h8);
        chk("mid_pre_out_valid", 64'(io.out_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_out_valid", 64'(io.out_valid), 64'd0);
        chk("mid_eng_ld",    64'(eng_ld),       64'hF);
        chk("mid_in_ready",  64'(io.in_ready),  64'd1);
        chk("mid_busy",      64'(busy),         64'd0);
        rst = 1'b0;
        io.out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (io.out_valid) seen = 1'b1;
        end
        chk("mid_no_stale_result", 64'(seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
